// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM arbiter slice.
// No logic: constants, the FSM state type and the refresh interval helper.
// No backpressure: compile-time definitions only.
package sdram_pkg;

    localparam int SDRAM_AW = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    // Clock cycles between auto-refresh requests.
    function automatic int refresh_cycles(input int freq, input int refresh_us);
        return freq / 1_000_000 * refresh_us;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesting ports, starting just after the last grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the grant.
module rr_arbiter #(
    parameter int NPORT = 3,
    parameter int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest port back to last_grant+1 so the nearest requester is written last and wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = '0;
        for (int k = NPORT; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant_i) + k) % NPORT);
            if (req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between NPORT requesters and schedules auto-refresh.
// Latency: command one cycle after arbitration, ack one cycle after controller busy drops.
// Backpressure: requesters hold req until ack; nothing is issued while sd_busy is high.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int FREQ       = 54_000_000,
    parameter int NPORT      = 3,
    parameter int REFRESH_US = 15
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NPORT-1:0]          req,
    input  logic [NPORT-1:0]          we,
    input  logic [NPORT*SDRAM_AW-1:0] addr,
    input  logic [NPORT*8-1:0]        wdata,
    output logic [NPORT-1:0]          ack,
    output logic [7:0]                rdata,
    output logic                      refresh_overrun,
    output logic                      sd_rd,
    output logic                      sd_wr,
    output logic                      sd_refresh,
    output logic [SDRAM_AW-1:0]       sd_addr,
    output logic [7:0]                sd_din,
    input  logic [7:0]                sd_dout,
    input  logic                      sd_data_ready,
    input  logic                      sd_busy
);

    localparam int RC    = refresh_cycles(FREQ, REFRESH_US);
    localparam int CNT_W = $clog2(RC);
    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    arb_state_t          state_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [IDX_W-1:0]    owner_q;
    logic                owner_vld_q;
    logic                sd_rd_q, sd_wr_q, sd_ref_q;
    logic [SDRAM_AW-1:0] sd_addr_q;
    logic [7:0]          sd_din_q;
    logic [NPORT-1:0]    ack_q;
    logic [7:0]          rdata_q;

    logic [CNT_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic                ref_pend_q;
    logic                overrun_q;
    logic                wrap;
    logic                issue_ref;

    logic                grant_vld;
    logic [IDX_W-1:0]    grant_idx;

    rr_arbiter #(
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i         (req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_vld),
        .grant_idx_o   (grant_idx)
    );

    assign wrap      = (ref_cnt_q == CNT_W'(RC - 1));
    assign ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;
    // A refresh leaves IDLE exactly when the FSM below loads sd_refresh.
    assign issue_ref = (state_q == IDLE) && !sd_busy && ref_pend_q;

    // Free-running refresh timer; a wrap sets the pending bit and wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            overrun_q <= wrap && ref_pend_q;
            if (wrap) begin
                ref_pend_q <= 1'b1;
            end else if (issue_ref) begin
                ref_pend_q <= 1'b0;
            end
        end
    end

    // Access sequencer: arbitrate, pulse the command, wait out busy, then ack the owner.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NPORT - 1);
            owner_q      <= '0;
            owner_vld_q  <= 1'b0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            sd_ref_q     <= 1'b0;
            sd_addr_q    <= '0;
            sd_din_q     <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (!sd_busy) begin
                        if (ref_pend_q) begin
                            sd_ref_q    <= 1'b1;
                            owner_vld_q <= 1'b0;
                            state_q     <= CMD;
                        end else if (grant_vld) begin
                            sd_rd_q      <= ~we[grant_idx];
                            sd_wr_q      <= we[grant_idx];
                            sd_addr_q    <= addr[grant_idx*SDRAM_AW +: SDRAM_AW];
                            sd_din_q     <= wdata[grant_idx*8 +: 8];
                            last_grant_q <= grant_idx;
                            owner_q      <= grant_idx;
                            owner_vld_q  <= 1'b1;
                            state_q      <= CMD;
                        end
                    end
                end
                CMD: begin
                    sd_rd_q  <= 1'b0;
                    sd_wr_q  <= 1'b0;
                    sd_ref_q <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (sd_data_ready) begin
                        rdata_q <= sd_dout;
                    end
                    if (!sd_busy) begin
                        // Ack is loaded here so it is visible for the whole DONE cycle.
                        if (owner_vld_q) begin
                            ack_q[owner_q] <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack             = ack_q;
    assign rdata           = rdata_q;
    assign refresh_overrun = overrun_q;
    assign sd_rd           = sd_rd_q;
    assign sd_wr           = sd_wr_q;
    assign sd_refresh      = sd_ref_q;
    assign sd_addr         = sd_addr_q;
    assign sd_din          = sd_din_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single byte-wide SDRAM controller (rd/wr/refresh/busy/data_ready interface) between NPORT requesters, e.g. CPU, PPU and loader.
- Issues the periodic auto-refresh on its own schedule.
- Sequences each access (one-cycle command pulse, wait on busy), captures read data and returns it with a one-cycle ack.
- Sits between the system memory map and the SDRAM controller; it is the only driver of the controller's command inputs.

Parameters:
- FREQ, 54_000_000, clk frequency in Hz.
- NPORT, 3, number of requester ports (2..4).
- REFRESH_US, 15, refresh interval in µs. REFRESH_CYCLES = FREQ/1_000_000*REFRESH_US (810 at default).

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- resetn  in  1  synchronous, active-low reset.
- req  in  NPORT  per-port request level. Held, with we/addr/wdata stable, until ack.
- we  in  NPORT  per-port: 1 = write, 0 = read.
- addr  in  NPORT*26  per-port byte address; port i uses bits [26i+25:26i].
- wdata  in  NPORT*8  per-port write byte.
- ack  out  NPORT  one-cycle completion pulse for the owning port.
- rdata  out  8  read byte; valid in the ack cycle of a read, held until the next read capture.
- refresh_overrun  out  1  one-cycle pulse when a refresh interval expires while a refresh is still pending.
- sd_rd  out  1  read command to the controller.
- sd_wr  out  1  write command to the controller.
- sd_refresh  out  1  refresh command to the controller.
- sd_addr  out  26  command address.
- sd_din  out  8  command write data.
- sd_dout  in  8  controller read data.
- sd_data_ready  in  1  controller read-data strobe.
- sd_busy  in  1  controller busy; high during power-up init and during each operation.

Behaviour:
- Reset values: all outputs 0, state IDLE, refresh counter 0, refresh_pend 0, round-robin pointer such that port 0 has top priority.
- All outputs are registered.
- FSM states: IDLE, CMD, WAIT, DONE.
- IDLE:
  - Arbitrates only when sd_busy == 0. This blocks all traffic during controller init.
  - If refresh_pend: load sd_refresh = 1, clear refresh_pend, go to CMD with owner = none.
  - Else if any req: pick the winner by round robin, searching from last_grant+1 upward with wrap. Load sd_rd = ~we[w] or sd_wr = we[w], sd_addr and sd_din from port w, set last_grant = w, go to CMD.
  - Else stay in IDLE.
- CMD: command strobes are high for exactly this one cycle. The controller accepts on this edge and raises sd_busy on the same edge. Deassert all strobes and go to WAIT. sd_addr/sd_din hold until the next command.
- WAIT:
  - When sd_data_ready == 1, latch rdata <= sd_dout.
  - When sd_busy == 0, go to DONE.
- DONE:
  - ack[owner] = 1 for this one cycle (no ack for refresh).
  - Go to IDLE.
  - A requester may drop req or present a new request after seeing ack. The following IDLE cycle re-arbitrates with the updated req.
- Refresh timer:
  - Free-running counter, 0..REFRESH_CYCLES-1. On wrap, set refresh_pend.
  - If refresh_pend is already 1 at wrap, pulse refresh_overrun. The pending bit stays 1; it does not count.
  - Refresh beats any pending port request, but never pre-empts an access already in flight.
- Simultaneous events:
  - A timer wrap in the same cycle that IDLE issues a refresh leaves refresh_pend = 1. The clear loses to the set.
- Port requests with req low are ignored regardless of we/addr.
- Reset mid-operation: state returns to IDLE, strobes drop, no ack is issued for the aborted access.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,0,… Worst-case wait is (NPORT-1) accesses plus one refresh.

Decomposition:
- Shared package (sdram_pkg) holds:
  - SDRAM_AW = 26.
  - arb_state_t enum {IDLE, CMD, WAIT, DONE}.
  - REFRESH_CYCLES function of FREQ and REFRESH_US.
- One sub-module, rr_arbiter:
  - Inputs: req[NPORT], last_grant.
  - Outputs: grant_valid, grant_idx.
  - Combinational rotate-priority-encode.
- The top level holds the FSM, refresh timer, data capture and command registers.

Test Plan:
- Init gating: hold sd_busy = 1 for 1000 cycles with req[0] high -> no sd_* strobe. Then drop sd_busy -> sd_rd pulses within 2 cycles.
- Single read: port 1 reads 0x000123, model returns 0xA5 on sd_data_ready -> sd_addr = 0x000123, exactly one sd_rd cycle, ack[1] one cycle after sd_busy falls, rdata = 0xA5.
- Single write: port 2 writes 0x3C to 0x1FFFFFF -> sd_wr one cycle, sd_din = 0x3C, sd_addr = 0x1FFFFFF, ack[2] pulse, rdata unchanged.
- Round robin: ports 0, 1 and 2 all hold req -> grant order 0,1,2,0,1,2 over 6 accesses, each ack one cycle.
- Refresh: idle for 810 cycles -> sd_refresh pulse and no ack. Hold the model's sd_busy high for more than 810 cycles after a refresh -> refresh_overrun pulse, then exactly one sd_refresh once busy clears, issued ahead of a pending req[0].
- Reset mid-read: assert resetn = 0 during WAIT -> all outputs 0 next cycle, no ack. After release, a new port-0 read completes normally.
